// File: rtl/axi_xbar_pkg.sv
// Shared definitions for the 2x2 AXI interconnect read/write sequencers:
// FSM encoding, one-hot slave selects, response codes and the default address map.
package axi_xbar_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_DERR_ADDR,
    ST_DERR_DATA
  } rd_state_t;

  localparam logic [2:0] SEL_NONE = 3'b000;
  localparam logic [2:0] SEL_S0   = 3'b001;
  localparam logic [2:0] SEL_S1   = 3'b010;
  localparam logic [2:0] SEL_DEF  = 3'b100;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [31:0] DEF_S0_BASE = 32'h0000_0000;
  localparam logic [31:0] DEF_S0_MASK = 32'hFFFF_0000;
  localparam logic [31:0] DEF_S1_BASE = 32'h0001_0000;
  localparam logic [31:0] DEF_S1_MASK = 32'hFFFF_0000;

endpackage

// File: rtl/axi_read_grant_ctrl_if.sv
// Bundle of AR/R handshake inputs and steering outputs of the read grant controller.
// The slave modport is the controller's view; master is the bus/driver view.
interface axi_read_grant_ctrl_if #(
  parameter int LEN_W = 4,
  parameter int ID_W  = 4
);
  logic              ARVALID_M0, ARVALID_M1;
  logic [31:0]       ARADDR_M0, ARADDR_M1;
  logic [LEN_W-1:0]  ARLEN_M0, ARLEN_M1;
  logic [ID_W-1:0]   ARID_M0, ARID_M1;
  logic              ARREADY_S0, ARREADY_S1;
  logic              RVALID_S0, RVALID_S1;
  logic              RLAST_S0, RLAST_S1;
  logic              RREADY_M0, RREADY_M1;

  logic              ARREADY_M0, ARREADY_M1;
  logic [1:0]        grant_m;
  logic [2:0]        sel_s;
  logic              ar_phase;
  logic              r_phase;
  logic              ds_rvalid;
  logic              ds_rlast;
  logic [1:0]        ds_rresp;
  logic [ID_W-1:0]   ds_rid;
  logic              ds_rdata_zero;

  modport slave (
    input  ARVALID_M0, ARVALID_M1, ARADDR_M0, ARADDR_M1, ARLEN_M0, ARLEN_M1,
           ARID_M0, ARID_M1, ARREADY_S0, ARREADY_S1, RVALID_S0, RVALID_S1,
           RLAST_S0, RLAST_S1, RREADY_M0, RREADY_M1,
    output ARREADY_M0, ARREADY_M1, grant_m, sel_s, ar_phase, r_phase,
           ds_rvalid, ds_rlast, ds_rresp, ds_rid, ds_rdata_zero
  );

  modport master (
    output ARVALID_M0, ARVALID_M1, ARADDR_M0, ARADDR_M1, ARLEN_M0, ARLEN_M1,
           ARID_M0, ARID_M1, ARREADY_S0, ARREADY_S1, RVALID_S0, RVALID_S1,
           RLAST_S0, RLAST_S1, RREADY_M0, RREADY_M1,
    input  ARREADY_M0, ARREADY_M1, grant_m, sel_s, ar_phase, r_phase,
           ds_rvalid, ds_rlast, ds_rresp, ds_rid, ds_rdata_zero
  );
endinterface

// File: rtl/axi_addr_decode.sv
// Combinational address decoder: maps an AXI address onto a one-hot slave select.
// S0 has priority over S1 when the windows overlap; anything unmapped goes to DEF.
module axi_addr_decode
  import axi_xbar_pkg::*;
#(
  parameter logic [31:0] S0_BASE = DEF_S0_BASE,
  parameter logic [31:0] S0_MASK = DEF_S0_MASK,
  parameter logic [31:0] S1_BASE = DEF_S1_BASE,
  parameter logic [31:0] S1_MASK = DEF_S1_MASK
) (
  input  logic [31:0] addr,
  output logic [2:0]  sel
);

  always_comb begin
    sel = SEL_DEF;
    if ((addr & S0_MASK) == S0_BASE) begin
      sel = SEL_S0;
    end else if ((addr & S1_MASK) == S1_BASE) begin
      sel = SEL_S1;
    end
  end

endmodule

// File: rtl/axi_read_grant_ctrl.sv
// Read-side sequencer: round-robin AR arbitration between two masters, grant held
// until the last R beat, and an internal default slave answering unmapped reads.
module axi_read_grant_ctrl
  import axi_xbar_pkg::*;
#(
  parameter logic [31:0] S0_BASE = DEF_S0_BASE,
  parameter logic [31:0] S0_MASK = DEF_S0_MASK,
  parameter logic [31:0] S1_BASE = DEF_S1_BASE,
  parameter logic [31:0] S1_MASK = DEF_S1_MASK,
  parameter int          LEN_W   = 4,
  parameter int          ID_W    = 4
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  axi_read_grant_ctrl_if.slave  bus
);

  logic [1:0]       arvalid, rready, arready_s, rvalid_s, rlast_s;
  logic [31:0]      araddr  [2];
  logic [LEN_W-1:0] arlen   [2];
  logic [ID_W-1:0]  arid    [2];
  logic [2:0]       dec_sel [2];

  assign arvalid   = {bus.ARVALID_M1, bus.ARVALID_M0};
  assign rready    = {bus.RREADY_M1, bus.RREADY_M0};
  assign arready_s = {bus.ARREADY_S1, bus.ARREADY_S0};
  assign rvalid_s  = {bus.RVALID_S1, bus.RVALID_S0};
  assign rlast_s   = {bus.RLAST_S1, bus.RLAST_S0};
  assign araddr[0] = bus.ARADDR_M0;
  assign araddr[1] = bus.ARADDR_M1;
  assign arlen[0]  = bus.ARLEN_M0;
  assign arlen[1]  = bus.ARLEN_M1;
  assign arid[0]   = bus.ARID_M0;
  assign arid[1]   = bus.ARID_M1;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dec
    axi_addr_decode #(
      .S0_BASE(S0_BASE), .S0_MASK(S0_MASK),
      .S1_BASE(S1_BASE), .S1_MASK(S1_MASK)
    ) u_dec (
      .addr(araddr[gi]),
      .sel (dec_sel[gi])
    );
  end

  rd_state_t        state_reg, state_next;
  logic             ptr_reg, ptr_next;
  logic             win_reg, win_next;
  logic [2:0]       sel_reg, sel_next;
  logic [LEN_W-1:0] len_reg, len_next;
  logic [ID_W-1:0]  id_reg, id_next;
  logic [LEN_W:0]   beat_reg, beat_next;

  logic [1:0] arready_m;
  logic       ar_phase, r_phase, ds_rvalid, ds_rlast;
  logic       pick, s_idx, beat_last;

  // A lone requester wins outright; contention is settled by the pointer.
  assign pick      = (&arvalid) ? ptr_reg : arvalid[1];
  assign s_idx     = sel_reg[1];
  assign beat_last = (beat_reg == {1'b0, len_reg});

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    win_next   = win_reg;
    sel_next   = sel_reg;
    len_next   = len_reg;
    id_next    = id_reg;
    beat_next  = beat_reg;
    arready_m  = 2'b00;
    ar_phase   = 1'b0;
    r_phase    = 1'b0;
    ds_rvalid  = 1'b0;
    ds_rlast   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (|arvalid) begin
          win_next   = pick;
          sel_next   = dec_sel[pick];
          len_next   = arlen[pick];
          id_next    = arid[pick];
          beat_next  = '0;
          state_next = (dec_sel[pick] == SEL_DEF) ? ST_DERR_ADDR : ST_ADDR;
        end
      end
      ST_ADDR: begin
        ar_phase           = 1'b1;
        arready_m[win_reg] = arready_s[s_idx];
        if (arvalid[win_reg] && arready_s[s_idx]) begin
          state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        r_phase = 1'b1;
        if (rvalid_s[s_idx] && rready[win_reg]) begin
          beat_next = beat_reg + {{LEN_W{1'b0}}, 1'b1};
          if (rlast_s[s_idx]) begin
            state_next = ST_IDLE;
            ptr_next   = ~win_reg;
          end
        end
      end
      ST_DERR_ADDR: begin
        ar_phase           = 1'b1;
        arready_m[win_reg] = 1'b1;
        state_next         = ST_DERR_DATA;
      end
      ST_DERR_DATA: begin
        r_phase   = 1'b1;
        ds_rvalid = 1'b1;
        ds_rlast  = beat_last;
        if (rready[win_reg]) begin
          if (beat_last) begin
            state_next = ST_IDLE;
            ptr_next   = ~win_reg;
          end else begin
            beat_next = beat_reg + {{LEN_W{1'b0}}, 1'b1};
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_reg <= ST_IDLE;
      ptr_reg   <= 1'b0;
      win_reg   <= 1'b0;
      sel_reg   <= SEL_NONE;
      len_reg   <= '0;
      id_reg    <= '0;
      beat_reg  <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      win_reg   <= win_next;
      sel_reg   <= sel_next;
      len_reg   <= len_next;
      id_reg    <= id_next;
      beat_reg  <= beat_next;
    end
  end

  // Grant and routing are only visible while a transaction owns the channel.
  assign bus.grant_m       = (state_reg == ST_IDLE) ? 2'b00 : (win_reg ? 2'b10 : 2'b01);
  assign bus.sel_s         = (state_reg == ST_IDLE) ? SEL_NONE : sel_reg;
  assign bus.ARREADY_M0    = arready_m[0];
  assign bus.ARREADY_M1    = arready_m[1];
  assign bus.ar_phase      = ar_phase;
  assign bus.r_phase       = r_phase;
  assign bus.ds_rvalid     = ds_rvalid;
  assign bus.ds_rlast      = ds_rlast;
  assign bus.ds_rresp      = ds_rvalid ? RESP_DECERR : RESP_OKAY;
  assign bus.ds_rid        = ds_rvalid ? id_reg : '0;
  assign bus.ds_rdata_zero = (bus.sel_s == SEL_DEF);

endmodule

// File: tb/tb_axi_read_grant_ctrl.sv
// Directed bench for axi_read_grant_ctrl with a transaction-level reference model
// compared against every output on each falling clock edge.
module tb_axi_read_grant_ctrl;

  logic ACLK;
  logic ARESETn;
  int   vectors = 0;
  int   fails   = 0;
  bit   chk_en  = 0;

  axi_read_grant_ctrl_if #(.LEN_W(4), .ID_W(4)) bus ();

  axi_read_grant_ctrl #(.LEN_W(4), .ID_W(4)) dut (
    .ACLK   (ACLK),
    .ARESETn(ARESETn),
    .bus    (bus)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  typedef struct packed {
    logic act;      // a read currently owns the channel
    logic m;        // owning master
    int   tgt;      // 0=S0, 1=S1, 2=default slave
    int   len;
    int   id;
    logic ar_done;  // address accepted, now in the data part
    int   beats;    // beats already delivered
    logic ptr;      // master favoured on contention
  } model_t;

  model_t mdl;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int tgt_of(input logic [31:0] a);
    if (a < 32'h0001_0000) return 0;
    if (a < 32'h0002_0000) return 1;
    return 2;
  endfunction

  function automatic logic s_arready(input int t);
    return (t == 0) ? bus.ARREADY_S0 : bus.ARREADY_S1;
  endfunction
  function automatic logic s_rvalid(input int t);
    return (t == 0) ? bus.RVALID_S0 : bus.RVALID_S1;
  endfunction
  function automatic logic s_rlast(input int t);
    return (t == 0) ? bus.RLAST_S0 : bus.RLAST_S1;
  endfunction
  function automatic logic m_rready(input logic m);
    return m ? bus.RREADY_M1 : bus.RREADY_M0;
  endfunction
  function automatic logic m_arvalid(input logic m);
    return m ? bus.ARVALID_M1 : bus.ARVALID_M0;
  endfunction

  function automatic model_t model_step(input model_t s);
    model_t n;
    bit     done;
    n    = s;
    done = 0;
    if (!s.act) begin
      if (bus.ARVALID_M0 || bus.ARVALID_M1) begin
        if (bus.ARVALID_M0 && bus.ARVALID_M1) n.m = s.ptr;
        else n.m = bus.ARVALID_M1;
        n.tgt     = tgt_of(n.m ? bus.ARADDR_M1 : bus.ARADDR_M0);
        n.len     = int'(n.m ? bus.ARLEN_M1 : bus.ARLEN_M0);
        n.id      = int'(n.m ? bus.ARID_M1 : bus.ARID_M0);
        n.act     = 1;
        n.ar_done = 0;
        n.beats   = 0;
      end
    end else if (!s.ar_done) begin
      if (s.tgt == 2 || (m_arvalid(s.m) && s_arready(s.tgt))) n.ar_done = 1;
    end else if (s.tgt == 2) begin
      if (m_rready(s.m)) begin
        if (s.beats == s.len) done = 1;
        else n.beats = s.beats + 1;
      end
    end else if (s_rvalid(s.tgt) && m_rready(s.m)) begin
      n.beats = s.beats + 1;
      if (s_rlast(s.tgt)) done = 1;
    end
    if (done) begin
      n.act = 0;
      n.ptr = !s.m;
    end
    return n;
  endfunction

  always @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) mdl <= '0;
    else          mdl <= model_step(mdl);
  end

  always @(negedge ACLK) begin
    if (chk_en) begin
      logic [1:0] e_grant;
      logic [2:0] e_sel;
      logic       ap, rp, arr, dsv;
      e_grant = mdl.act ? (mdl.m ? 2'b10 : 2'b01) : 2'b00;
      e_sel   = !mdl.act ? 3'b000 : (mdl.tgt == 0) ? 3'b001 : (mdl.tgt == 1) ? 3'b010 : 3'b100;
      ap      = mdl.act && !mdl.ar_done;
      rp      = mdl.act && mdl.ar_done;
      arr     = ap && ((mdl.tgt == 2) ? 1'b1 : s_arready(mdl.tgt));
      dsv     = rp && (mdl.tgt == 2);
      chk("grant_m", 32'(bus.grant_m), 32'(e_grant));
      chk("sel_s", 32'(bus.sel_s), 32'(e_sel));
      chk("ar_phase", 32'(bus.ar_phase), 32'(ap));
      chk("r_phase", 32'(bus.r_phase), 32'(rp));
      chk("arready_m0", 32'(bus.ARREADY_M0), 32'(arr && !mdl.m));
      chk("arready_m1", 32'(bus.ARREADY_M1), 32'(arr && mdl.m));
      chk("ds_rvalid", 32'(bus.ds_rvalid), 32'(dsv));
      chk("ds_rlast", 32'(bus.ds_rlast), 32'(dsv && mdl.beats == mdl.len));
      chk("ds_rresp", 32'(bus.ds_rresp), dsv ? 32'd3 : 32'd0);
      chk("ds_rid", 32'(bus.ds_rid), dsv ? 32'(mdl.id) : 32'd0);
      chk("ds_rdata_zero", 32'(bus.ds_rdata_zero), 32'(mdl.act && mdl.tgt == 2));
    end
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic set_req(input logic m, input logic [31:0] a, input int len, input int id);
    if (m) begin
      bus.ARVALID_M1 = 1; bus.ARADDR_M1 = a; bus.ARLEN_M1 = 4'(len); bus.ARID_M1 = 4'(id);
    end else begin
      bus.ARVALID_M0 = 1; bus.ARADDR_M0 = a; bus.ARLEN_M0 = 4'(len); bus.ARID_M0 = 4'(id);
    end
  endtask

  task automatic clr_req(input logic m);
    if (m) bus.ARVALID_M1 = 0;
    else   bus.ARVALID_M0 = 0;
  endtask

  task automatic set_slave(input logic t, input logic arr, input logic rv, input logic rl);
    if (t) begin
      bus.ARREADY_S1 = arr; bus.RVALID_S1 = rv; bus.RLAST_S1 = rl;
    end else begin
      bus.ARREADY_S0 = arr; bus.RVALID_S0 = rv; bus.RLAST_S0 = rl;
    end
  endtask

  // One read of (len+1) beats to a mapped slave; assumes master m wins the next decision.
  task automatic s_burst(input logic m, input logic [31:0] a, input int len, input int ar_wait,
                         input logic [1:0] exp_grant, input logic [2:0] exp_sel);
    logic t;
    t = exp_sel[1];
    set_req(m, a, len, m ? 9 : 3);
    tick();
    chk("lit_grant", 32'(bus.grant_m), 32'(exp_grant));
    chk("lit_sel", 32'(bus.sel_s), 32'(exp_sel));
    for (int w = 0; w < ar_wait; w++) begin
      chk("lit_arready_wait", 32'(m ? bus.ARREADY_M1 : bus.ARREADY_M0), 32'd0);
      chk("lit_ar_phase_wait", 32'(bus.ar_phase), 32'd1);
      tick();
    end
    set_slave(t, 1, 0, 0);
    #1;
    chk("lit_arready", 32'(m ? bus.ARREADY_M1 : bus.ARREADY_M0), 32'd1);
    tick();
    set_slave(t, 0, 0, 0);
    clr_req(m);
    chk("lit_r_phase", 32'(bus.r_phase), 32'd1);
    for (int b = 0; b <= len; b++) begin
      chk("lit_grant_hold", 32'(bus.grant_m), 32'(exp_grant));
      set_slave(t, 0, 1, (b == len));
      tick();
    end
    set_slave(t, 0, 0, 0);
    chk("lit_idle_after", 32'({bus.grant_m, bus.r_phase}), 32'd0);
  endtask

  task automatic do_reset();
    ARESETn = 0;
    repeat (2) tick();
    ARESETn = 1;
  endtask

  initial begin
    int acc;
    int cyc;
    ARESETn = 0;
    bus.ARVALID_M0 = 0; bus.ARVALID_M1 = 0;
    bus.ARADDR_M0 = '0; bus.ARADDR_M1 = '0;
    bus.ARLEN_M0 = '0;  bus.ARLEN_M1 = '0;
    bus.ARID_M0 = '0;   bus.ARID_M1 = '0;
    bus.RREADY_M0 = 1;  bus.RREADY_M1 = 1;
    set_slave(0, 0, 0, 0);
    set_slave(1, 0, 0, 0);
    tick();
    chk_en = 1;
    tick();
    chk("lit_reset_grant", 32'(bus.grant_m), 32'd0);
    chk("lit_reset_sel", 32'(bus.sel_s), 32'd0);
    ARESETn = 1;
    tick();

    // 4-beat S0 read from M0; pointer then favours M1 under contention.
    s_burst(0, 32'h0000_0040, 3, 0, 2'b01, 3'b001);
    set_req(0, 32'h0000_0100, 1, 3);
    s_burst(1, 32'h0001_0000, 1, 0, 2'b10, 3'b010);
    s_burst(0, 32'h0000_0100, 1, 0, 2'b01, 3'b001);

    // Contention from reset: M0, then M1, then M0 again.
    do_reset();
    set_req(1, 32'h0001_0000, 2, 9);
    s_burst(0, 32'h0000_0000, 1, 0, 2'b01, 3'b001);
    set_req(0, 32'h0000_0040, 2, 3);
    s_burst(1, 32'h0001_0000, 2, 0, 2'b10, 3'b010);
    s_burst(0, 32'h0000_0040, 2, 0, 2'b01, 3'b001);

    // Unmapped read from M1: DECERR burst of 3 beats with RREADY toggling.
    set_req(1, 32'h8000_0000, 2, 5);
    bus.RREADY_M1 = 0;
    tick();
    chk("lit_derr_arready", 32'(bus.ARREADY_M1), 32'd1);
    chk("lit_derr_sel", 32'(bus.sel_s), 32'd4);
    tick();
    clr_req(1);
    chk("lit_derr_arready_pulse", 32'(bus.ARREADY_M1), 32'd0);
    acc = 0;
    cyc = 0;
    while (acc < 3 && cyc < 40) begin
      bus.RREADY_M1 = cyc[0];
      #1;
      chk("lit_ds_rvalid", 32'(bus.ds_rvalid), 32'd1);
      chk("lit_ds_rlast", 32'(bus.ds_rlast), 32'(acc == 2));
      chk("lit_ds_rresp", 32'(bus.ds_rresp), 32'd3);
      chk("lit_ds_rid", 32'(bus.ds_rid), 32'd5);
      tick();
      if (cyc[0]) acc++;
      cyc++;
    end
    chk("lit_derr_beats", 32'(acc), 32'd3);
    chk("lit_derr_done", 32'(bus.r_phase), 32'd0);
    bus.RREADY_M1 = 1;

    // Slave holds ARREADY low for 5 cycles.
    s_burst(0, 32'h0000_0200, 1, 5, 2'b01, 3'b001);

    // Reset during beat 2 of a 4-beat S1 burst.
    set_req(1, 32'h0001_0000, 3, 7);
    tick();
    set_slave(1, 1, 0, 0);
    tick();
    clr_req(1);
    set_slave(1, 0, 1, 0);
    tick();
    #2;
    ARESETn = 0;
    #1;
    chk("lit_rst_grant", 32'(bus.grant_m), 32'd0);
    chk("lit_rst_sel", 32'(bus.sel_s), 32'd0);
    chk("lit_rst_r_phase", 32'(bus.r_phase), 32'd0);
    tick();
    set_slave(1, 0, 0, 0);
    ARESETn = 1;
    tick();
    set_req(1, 32'h0001_0000, 1, 9);
    s_burst(0, 32'h0000_0300, 1, 0, 2'b01, 3'b001);
    s_burst(1, 32'h0001_0000, 1, 0, 2'b10, 3'b010);

    // ARLEN=0 to S0: single beat, single DATA cycle.
    s_burst(0, 32'h0000_0000, 0, 0, 2'b01, 3'b001);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
